ama_riscv_writeback: RTL and testbench
======================================

Name: ama_riscv_writeback

Overview:
- Final pipeline stage of the core; sits directly upstream of the register file and drives its write port (we, addr_d, data_d).
- Accepts the retiring instruction from the MEM stage and aligns and extends load data returned by data memory.
- Selects the writeback source and registers the result into the WB stage.
- Stalls MEM while a load response is outstanding, exposes a same-cycle bypass for decode, and keeps the retired-instruction and load-stall counters.

Parameters:
- INSTRET_W, 64, width of retired-instruction counter; wraps to 0.
- STALL_CNT_W, 32, width of load-wait cycle counter; saturates at all-ones.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_rd_we  in  1  instruction writes rd
- mem_rd_addr  in  rf_addr_t  destination register
- mem_wb_sel  in  wb_sel_t  writeback source: ALU, LOAD, PC4, CSR
- mem_alu_out  in  32  ALU result; the load address for loads
- mem_pc_inc4  in  32  PC+4 for jal/jalr
- mem_csr_data  in  32  CSR read data
- mem_funct3  in  3  load width/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- dmem_rsp_valid  in  1  load response valid
- dmem_rsp_data  in  32  word-aligned load data
- mem_stall  out  1  hold MEM and all earlier stages
- rf_we  out  1  register file write enable
- rf_addr_d  out  rf_addr_t  register file write address
- rf_data_d  out  32  register file write data
- misalign_err  out  1  one-cycle pulse for a misaligned load
- instret  out  INSTRET_W  retired-instruction count
- load_stall_cnt  out  STALL_CNT_W  cycles spent waiting on load responses

Behaviour:
- Reset (synchronous, active-high), applied on the rst clock edge:
  - wb_valid=0, rf_we=0, rf_addr_d=0, rf_data_d=0, misalign_err=0.
  - instret=0, load_stall_cnt=0, FSM=IDLE.
  - mem_stall is forced to 0 while rst=1.
- Accept condition: accept = mem_valid && !mem_stall. The WB register captures on accept; otherwise wb_valid=0 next cycle (bubble).
- Latency: accepted in cycle N -> rf_we/rf_addr_d/rf_data_d valid in cycle N+1 -> value readable from the register file in cycle N+2.
- Bypass: decode compares its source addresses against rf_addr_d while rf_we=1; no extra port is needed.
- rf_we = wb_valid && wb_rd_we && (rf_addr_d != RF_X0_ZERO).
- Writes to x0 retire but never assert rf_we.
- Source mux by wb_sel:
  - ALU -> mem_alu_out
  - PC4 -> mem_pc_inc4
  - CSR -> mem_csr_data
  - LOAD -> aligned load data
- Load align: shift dmem_rsp_data right by 8*mem_alu_out[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes unchanged.
  - Unsupported funct3 values are treated as LW.
- Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Instruction is accepted; no rf write; no instret increment.
  - misalign_err pulses in cycle N+1.
  - No wait for a response: a misaligned load never stalls.
- Load FSM:
  - IDLE: load present and dmem_rsp_valid=1 -> accept the same cycle, no stall.
  - IDLE: load present and dmem_rsp_valid=0 -> mem_stall=1, go to WAIT.
  - WAIT: mem_stall=1 and load_stall_cnt increments each cycle until dmem_rsp_valid=1.
  - WAIT, response cycle: mem_stall=0, accept, go to IDLE.
  - The IDLE->WAIT cycle also counts as a stall cycle.
- mem_stall is combinational: mem_valid && wb_sel==LOAD && !misaligned && !dmem_rsp_valid && !rst.
- A dmem_rsp_valid with no load in MEM is ignored and state is unchanged.
- Reset during WAIT: FSM goes to IDLE, the pending load is dropped, and a later response is ignored per the rule above.
- instret increments when wb_valid && !wb_misaligned; it wraps to 0 at all-ones.
- load_stall_cnt holds at all-ones.
- Stores and branches (mem_rd_we=0) still retire and count.

Decomposition:
- Shared package ama_riscv_defines holds:
  - rf_addr_t (5-bit)
  - RF_X0_ZERO
  - wb_sel_t enum: ALU=0, LOAD=1, PC4=2, CSR=3
  - load funct3 constants LB, LH, LW, LBU, LHU
- FSM state enum is local to this module.
- One sub-module: ama_riscv_load_align. It is combinational: rsp_data, addr_lo and funct3 in; aligned data and misaligned flag out.

Test Plan:
- ALU op, rd=x5, alu_out=0x1234_5678 -> next cycle rf_we=1, rf_addr_d=5, rf_data_d=0x1234_5678; instret=1.
- LB, addr_lo=3, rsp=0x80AB_CDEF -> rf_data_d=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH, addr_lo=2, rsp=0x7FFF_0000 -> 0x0000_7FFF.
- Load with response 3 cycles late -> mem_stall=1 for exactly 3 cycles; load_stall_cnt=3; one rf write; instret+1.
- LW with addr_lo=2 -> no stall, rf_we=0, misalign_err=1 for one cycle, instret unchanged.
- ALU op with rd=x0 -> rf_we=0 and instret increments.
- rst asserted mid-WAIT, then a response arrives -> all outputs at reset values, no rf write, FSM IDLE.
- instret preloaded to all-ones (force), one retire -> wraps to 0.

Source files
------------

// File: rtl/ama_riscv_defines.sv
// Shared types and constants for the ama_riscv core pipeline.
package ama_riscv_defines;

  typedef logic [4:0] rf_addr_t;

  localparam rf_addr_t RF_X0_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    PC4  = 2'd2,
    CSR  = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

endpackage

// File: rtl/ama_riscv_load_align.sv
// Aligns word-wide load data to the addressed byte/half and extends it;
// flags addresses the access width cannot reach.
module ama_riscv_load_align
  import ama_riscv_defines::*;
(
  input  logic [31:0] rsp_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = rsp_data >> {addr_lo, 3'b000};

  always_comb begin
    data       = shifted;
    misaligned = 1'b0;
    unique case (funct3)
      LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      LBU: data = {24'h0, shifted[7:0]};
      LH: begin
        data       = {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      LHU: begin
        data       = {16'h0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      // LW and any unsupported encoding: full word, must be word aligned
      default: begin
        data       = shifted;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/ama_riscv_writeback.sv
// Writeback stage: selects the result, aligns load data, drives the
// register file write port and keeps retire / load-wait counters.
module ama_riscv_writeback
  import ama_riscv_defines::*;
#(
  parameter int unsigned INSTRET_W   = 64,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  input  logic                   mem_rd_we,
  input  rf_addr_t               mem_rd_addr,
  input  wb_sel_t                mem_wb_sel,
  input  logic [31:0]            mem_alu_out,
  input  logic [31:0]            mem_pc_inc4,
  input  logic [31:0]            mem_csr_data,
  input  logic [2:0]             mem_funct3,
  input  logic                   dmem_rsp_valid,
  input  logic [31:0]            dmem_rsp_data,
  output logic                   mem_stall,
  output logic                   rf_we,
  output rf_addr_t               rf_addr_d,
  output logic [31:0]            rf_data_d,
  output logic                   misalign_err,
  output logic [INSTRET_W-1:0]   instret,
  output logic [STALL_CNT_W-1:0] load_stall_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state_q;
  logic                   wb_valid_q;
  logic                   wb_misaligned_q;
  logic                   rf_we_q;
  rf_addr_t               rf_addr_q;
  logic [31:0]            rf_data_q;
  logic                   misalign_err_q;
  logic [INSTRET_W-1:0]   instret_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic [31:0] load_data;
  logic        align_misaligned;
  logic        is_load;
  logic        load_mis;
  logic        accept;
  logic [31:0] wb_data;

  ama_riscv_load_align u_load_align (
    .rsp_data   (dmem_rsp_data),
    .addr_lo    (mem_alu_out[1:0]),
    .funct3     (mem_funct3),
    .data       (load_data),
    .misaligned (align_misaligned)
  );

  assign is_load   = mem_valid && (mem_wb_sel == LOAD);
  assign load_mis  = is_load && align_misaligned;
  // Misaligned loads never wait for a response.
  assign mem_stall = is_load && !align_misaligned && !dmem_rsp_valid && !rst;
  assign accept    = mem_valid && !mem_stall;

  always_comb begin
    wb_data = mem_alu_out;
    unique case (mem_wb_sel)
      ALU:     wb_data = mem_alu_out;
      LOAD:    wb_data = load_data;
      PC4:     wb_data = mem_pc_inc4;
      CSR:     wb_data = mem_csr_data;
      default: wb_data = mem_alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wb_valid_q      <= 1'b0;
      wb_misaligned_q <= 1'b0;
      rf_we_q         <= 1'b0;
      rf_addr_q       <= RF_X0_ZERO;
      rf_data_q       <= 32'h0;
      misalign_err_q  <= 1'b0;
      instret_q       <= '0;
      stall_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= mem_stall ? WAIT : IDLE;
        WAIT:    state_q <= mem_stall ? WAIT : IDLE;
        default: state_q <= IDLE;
      endcase
      wb_valid_q      <= accept;
      wb_misaligned_q <= accept && load_mis;
      rf_we_q         <= accept && mem_rd_we && (mem_rd_addr != RF_X0_ZERO) && !load_mis;
      misalign_err_q  <= accept && load_mis;
      if (accept) begin
        rf_addr_q <= mem_rd_addr;
        rf_data_q <= wb_data;
      end
      if (wb_valid_q && !wb_misaligned_q) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
      if (mem_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_addr_d      = rf_addr_q;
  assign rf_data_d      = rf_data_q;
  assign misalign_err   = misalign_err_q;
  assign instret        = instret_q;
  assign load_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ama_riscv_writeback.sv
// Directed bench for ama_riscv_writeback: vector table plus stall, reset
// and counter-wrap sequences.
module tb_ama_riscv_writeback;
  import ama_riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_rd_we;
  rf_addr_t    mem_rd_addr;
  wb_sel_t     mem_wb_sel;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_pc_inc4;
  logic [31:0] mem_csr_data;
  logic [2:0]  mem_funct3;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        mem_stall;
  logic        rf_we;
  rf_addr_t    rf_addr_d;
  logic [31:0] rf_data_d;
  logic        misalign_err;
  logic [63:0] instret;
  logic [31:0] load_stall_cnt;

  int checks   = 0;
  int failures = 0;
  longint unsigned exp_instret = 0;

  always #5 clk = ~clk;

  ama_riscv_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_rd_we      (mem_rd_we),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_out    (mem_alu_out),
    .mem_pc_inc4    (mem_pc_inc4),
    .mem_csr_data   (mem_csr_data),
    .mem_funct3     (mem_funct3),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .mem_stall      (mem_stall),
    .rf_we          (rf_we),
    .rf_addr_d      (rf_addr_d),
    .rf_data_d      (rf_data_d),
    .misalign_err   (misalign_err),
    .instret        (instret),
    .load_stall_cnt (load_stall_cnt)
  );

  typedef struct {
    wb_sel_t     sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rsp;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input wb_sel_t sel, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu);
    mem_valid   = 1'b1;
    mem_rd_we   = 1'b1;
    mem_wb_sel  = sel;
    mem_funct3  = f3;
    mem_rd_addr = rd;
    mem_alu_out = alu;
  endtask

  initial begin
    vecs[0]  = '{ALU,  LW,  5'd5,  32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[1]  = '{LOAD, LB,  5'd6,  32'h0000_2003, 32'h80AB_CDEF, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{LOAD, LBU, 5'd6,  32'h0000_2003, 32'h80AB_CDEF, 1'b1, 32'h0000_0080, 1'b0};
    vecs[3]  = '{LOAD, LH,  5'd8,  32'h0000_2002, 32'h7FFF_0000, 1'b1, 32'h0000_7FFF, 1'b0};
    vecs[4]  = '{PC4,  LW,  5'd1,  32'h0000_0AAA, 32'h0,         1'b1, 32'h0000_1004, 1'b0};
    vecs[5]  = '{CSR,  LW,  5'd2,  32'h0000_0BBB, 32'h0,         1'b1, 32'h5555_AAAA, 1'b0};
    vecs[6]  = '{LOAD, LHU, 5'd9,  32'h0000_3002, 32'h8001_0000, 1'b1, 32'h0000_8001, 1'b0};
    vecs[7]  = '{LOAD, LW,  5'd10, 32'h0000_3000, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{LOAD, LW,  5'd11, 32'h0000_3002, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{ALU,  LW,  5'd0,  32'h0000_0777, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[10] = '{LOAD, LB,  5'd12, 32'h0000_4001, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0};

    rst            = 1'b1;
    mem_pc_inc4    = 32'h0000_1004;
    mem_csr_data   = 32'h5555_AAAA;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_data  = 32'h0;
    set_op(LOAD, LW, 5'd4, 32'h0000_1000);
    #1;
    check("stall_in_reset", mem_stall, 0);
    tick();
    tick();
    check("rst_rf_we", rf_we, 0);
    check("rst_addr", rf_addr_d, 0);
    check("rst_data", rf_data_d, 0);
    check("rst_mis", misalign_err, 0);
    check("rst_instret", instret, 0);
    check("rst_stall_cnt", load_stall_cnt, 0);
    rst       = 1'b0;
    mem_valid = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i].sel, vecs[i].f3, vecs[i].rd, vecs[i].alu);
      dmem_rsp_valid = (vecs[i].sel == LOAD);
      dmem_rsp_data  = vecs[i].rsp;
      #1;
      check($sformatf("v%0d_stall", i), mem_stall, 0);
      tick();
      check($sformatf("v%0d_we", i), rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i), rf_addr_d, vecs[i].rd);
        check($sformatf("v%0d_data", i), rf_data_d, vecs[i].exp_data);
      end
      check($sformatf("v%0d_mis", i), misalign_err, vecs[i].exp_mis);
      if (!vecs[i].exp_mis) exp_instret++;
    end
    mem_valid      = 1'b0;
    dmem_rsp_valid = 1'b0;
    tick();
    tick();
    check("instret_after_table", instret, exp_instret);
    check("stall_cnt_after_table", load_stall_cnt, 0);

    // Load whose response arrives three cycles late
    set_op(LOAD, LW, 5'd7, 32'h0000_0100);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("late_stall%0d", k), mem_stall, 1);
      tick();
      check($sformatf("late_bubble%0d", k), rf_we, 0);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h0BAD_F00D;
    #1;
    check("late_rsp_stall", mem_stall, 0);
    tick();
    mem_valid      = 1'b0;
    dmem_rsp_valid = 1'b0;
    check("late_we", rf_we, 1);
    check("late_addr", rf_addr_d, 7);
    check("late_data", rf_data_d, 32'h0BAD_F00D);
    check("late_stall_cnt", load_stall_cnt, 3);
    exp_instret++;
    tick();
    check("late_we_once", rf_we, 0);
    check("late_instret", instret, exp_instret);

    // Reset while waiting, then a stray response
    set_op(LOAD, LW, 5'd13, 32'h0000_0200);
    tick();
    tick();
    check("wait_state", dut.state_q, 1);
    rst = 1'b1;
    #1;
    check("stall_rst_wait", mem_stall, 0);
    tick();
    check("rwait_we", rf_we, 0);
    check("rwait_addr", rf_addr_d, 0);
    check("rwait_data", rf_data_d, 0);
    check("rwait_instret", instret, 0);
    check("rwait_stall_cnt", load_stall_cnt, 0);
    check("rwait_state", dut.state_q, 0);
    rst            = 1'b0;
    mem_valid      = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1111_2222;
    tick();
    dmem_rsp_valid = 1'b0;
    check("stray_we", rf_we, 0);
    check("stray_state", dut.state_q, 0);
    tick();
    check("stray_instret", instret, 0);

    // instret wraps from all-ones
    force dut.instret_q = {64{1'b1}};
    set_op(ALU, LW, 5'd3, 32'h0000_0042);
    tick();
    release dut.instret_q;
    mem_valid = 1'b0;
    check("wrap_preload", instret, {64{1'b1}});
    tick();
    check("wrap_instret", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
